// File: rtl/ats21_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ats21_pkg
// Brief    : Opcodes, command field slices, FSM states and the same-target
//            conflict check shared by the ATS21 command issuer.
// Revision : 1.0
// ============================================================================
package ats21_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'b000,
        OP_SET_CLK = 3'b001,
        OP_EN_CLK  = 3'b010,
        OP_MODE    = 3'b011,
        OP_SET_ALM = 3'b101,
        OP_SET_TMR = 3'b110,
        OP_EN_ALM  = 3'b111
    } opcode_t;

    localparam int c_OP_MSB  = 31;
    localparam int c_OP_LSB  = 29;
    localparam int c_CLK_MSB = 28;
    localparam int c_CLK_LSB = 25;
    localparam int c_RES_MSB = 28;
    localparam int c_RES_LSB = 24;
    localparam int c_HI_LSB  = 16;
    localparam int c_LO_MSB  = 15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEAT1 = 3'd1,
        S_BEAT2 = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // True when two real commands would address the same core resource.
    function automatic logic cmd_conflict(input logic [31:0] cmd_a, input logic [31:0] cmd_b);
        logic [2:0] w_op_a;
        logic [2:0] w_op_b;
        logic       w_alm_a;
        logic       w_alm_b;
        logic       w_clk_hit;
        w_op_a    = cmd_a[c_OP_MSB:c_OP_LSB];
        w_op_b    = cmd_b[c_OP_MSB:c_OP_LSB];
        w_alm_a   = (w_op_a == OP_SET_ALM) || (w_op_a == OP_SET_TMR) || (w_op_a == OP_EN_ALM);
        w_alm_b   = (w_op_b == OP_SET_ALM) || (w_op_b == OP_SET_TMR) || (w_op_b == OP_EN_ALM);
        w_clk_hit = (w_op_a == w_op_b) && ((w_op_a == OP_SET_CLK) || (w_op_a == OP_EN_CLK)) &&
                    (cmd_a[c_CLK_MSB:c_CLK_LSB] == cmd_b[c_CLK_MSB:c_CLK_LSB]);
        return w_clk_hit ||
               (w_alm_a && w_alm_b && (cmd_a[c_RES_MSB:c_RES_LSB] == cmd_b[c_RES_MSB:c_RES_LSB])) ||
               ((w_op_a == OP_MODE) && (w_op_b == OP_MODE));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ats21_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ats21_cmd_fifo
// Brief    : 32-bit synchronous command FIFO with wrap-bit pointers; the head
//            entry is presented combinationally.
// Revision : 1.0
// ============================================================================
module ats21_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        empty,
    output logic        full
);

    localparam int             c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic [31:0]   r_mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
    end

    assign head  = r_mem[r_rd_ptr[c_AW-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/ats21_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : ats21_cmd_issuer
// Brief    : Two-client command front-end for the ATS21 timer core: buffers
//            32-bit commands, issues them as two 16-bit beats, returns ack/nack.
//            Define ATS21_CMD_RETRY_EN to re-issue Nacked commands.
// Revision : 1.0
// ============================================================================
module ats21_cmd_issuer
    import ats21_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STAT_LAT   = 2,
    parameter int MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [31:0] a_cmd,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [31:0] b_cmd,
    output logic        a_rsp_valid,
    output logic        a_rsp_ack,
    output logic        b_rsp_valid,
    output logic        b_rsp_ack,
    output logic        req,
    output logic [15:0] ctrlA,
    output logic [15:0] ctrlB,
    input  logic [1:0]  stat,
    output logic        busy
);

    localparam int                 c_CNT_W     = (STAT_LAT > 2) ? $clog2(STAT_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_CNT_W'(STAT_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    // Legal ranges: FIFO_DEPTH a power of two >= 2, STAT_LAT >= 1, MAX_RETRY 0..3.
    if ((FIFO_DEPTH < 2) || (STAT_LAT < 1) || (MAX_RETRY < 0) || (MAX_RETRY > 3)) begin : g_cfg_out_of_range
    end

    state_t             r_state;
    logic               r_sel_a;
    logic               r_sel_b;
    logic [31:0]        r_cmd_a;
    logic [31:0]        r_cmd_b;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_req;
    logic [15:0]        r_ctrl_a;
    logic [15:0]        r_ctrl_b;
    logic               r_a_rsp_valid;
    logic               r_a_rsp_ack;
    logic               r_b_rsp_valid;
    logic               r_b_rsp_ack;

    logic [31:0] w_a_head;
    logic [31:0] w_b_head;
    logic        w_a_empty;
    logic        w_b_empty;
    logic        w_a_full;
    logic        w_b_full;
    logic        w_a_push;
    logic        w_b_push;
    logic        w_a_pop;
    logic        w_b_pop;
    logic        w_a_real;
    logic        w_b_real;
    logic        w_a_nop;
    logic        w_b_nop;
    logic        w_take_a;
    logic        w_take_b;
    logic        w_a_done;
    logic        w_b_done;

    ats21_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk       (clk),
        .reset     (reset),
        .push      (w_a_push),
        .push_data (a_cmd),
        .pop       (w_a_pop),
        .head      (w_a_head),
        .empty     (w_a_empty),
        .full      (w_a_full)
    );

    ats21_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk       (clk),
        .reset     (reset),
        .push      (w_b_push),
        .push_data (b_cmd),
        .pop       (w_b_pop),
        .head      (w_b_head),
        .empty     (w_b_empty),
        .full      (w_b_full)
    );

    assign w_a_nop  = !w_a_empty && (w_a_head[c_OP_MSB:c_OP_LSB] == OP_NOP);
    assign w_b_nop  = !w_b_empty && (w_b_head[c_OP_MSB:c_OP_LSB] == OP_NOP);
    assign w_a_real = !w_a_empty && !w_a_nop;
    assign w_b_real = !w_b_empty && !w_b_nop;

    // A has fixed priority: a colliding B head waits for the next transaction.
    assign w_take_a = (r_state == S_IDLE) && w_a_real;
    assign w_take_b = (r_state == S_IDLE) && w_b_real &&
                      !(w_a_real && cmd_conflict(w_a_head, w_b_head));

    // Response flags are registered into RESP, so they double as the pop strobe there.
    assign w_a_pop  = ((r_state == S_IDLE) && w_a_nop) || ((r_state == S_RESP) && r_a_rsp_valid);
    assign w_b_pop  = ((r_state == S_IDLE) && w_b_nop) || ((r_state == S_RESP) && r_b_rsp_valid);

    assign a_ready  = reset && (!w_a_full || w_a_pop);
    assign b_ready  = reset && (!w_b_full || w_b_pop);
    assign w_a_push = a_valid && a_ready;
    assign w_b_push = b_valid && b_ready;

`ifdef ATS21_CMD_RETRY_EN
    localparam logic [1:0] c_MAX_TRY = 2'(MAX_RETRY);

    logic [1:0] r_try_a;
    logic [1:0] r_try_b;
    logic       w_a_again;
    logic       w_b_again;

    assign w_a_done  = r_sel_a && (stat[0] || (r_try_a == c_MAX_TRY));
    assign w_b_done  = r_sel_b && (stat[1] || (r_try_b == c_MAX_TRY));
    assign w_a_again = r_sel_a && !r_a_rsp_valid;
    assign w_b_again = r_sel_b && !r_b_rsp_valid;
`else
    assign w_a_done  = r_sel_a;
    assign w_b_done  = r_sel_b;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_sel_a       <= 1'b0;
            r_sel_b       <= 1'b0;
            r_cmd_a       <= '0;
            r_cmd_b       <= '0;
            r_wait_cnt    <= '0;
            r_req         <= 1'b0;
            r_ctrl_a      <= '0;
            r_ctrl_b      <= '0;
            r_a_rsp_valid <= 1'b0;
            r_a_rsp_ack   <= 1'b0;
            r_b_rsp_valid <= 1'b0;
            r_b_rsp_ack   <= 1'b0;
`ifdef ATS21_CMD_RETRY_EN
            r_try_a       <= '0;
            r_try_b       <= '0;
`endif
        end else begin
            r_a_rsp_valid <= 1'b0;
            r_a_rsp_ack   <= 1'b0;
            r_b_rsp_valid <= 1'b0;
            r_b_rsp_ack   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // NOP heads are answered Nack without touching the core.
                    if (w_a_nop) r_a_rsp_valid <= 1'b1;
                    if (w_b_nop) r_b_rsp_valid <= 1'b1;
                    if (w_take_a || w_take_b) begin
                        r_sel_a  <= w_take_a;
                        r_sel_b  <= w_take_b;
                        if (w_take_a) r_cmd_a <= w_a_head;
                        if (w_take_b) r_cmd_b <= w_b_head;
                        r_ctrl_a <= w_take_a ? w_a_head[31:c_HI_LSB] : '0;
                        r_ctrl_b <= w_take_b ? w_b_head[31:c_HI_LSB] : '0;
                        r_req    <= 1'b1;
                        r_state  <= S_BEAT1;
`ifdef ATS21_CMD_RETRY_EN
                        r_try_a  <= '0;
                        r_try_b  <= '0;
`endif
                    end
                end
                S_BEAT1: begin
                    r_req    <= 1'b0;
                    r_ctrl_a <= r_sel_a ? r_cmd_a[c_LO_MSB:0] : '0;
                    r_ctrl_b <= r_sel_b ? r_cmd_b[c_LO_MSB:0] : '0;
                    r_state  <= S_BEAT2;
                end
                S_BEAT2: begin
                    r_ctrl_a   <= '0;
                    r_ctrl_b   <= '0;
                    r_wait_cnt <= c_WAIT_LOAD;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_a_rsp_valid <= w_a_done;
                        r_a_rsp_ack   <= w_a_done && stat[0];
                        r_b_rsp_valid <= w_b_done;
                        r_b_rsp_ack   <= w_b_done && stat[1];
`ifdef ATS21_CMD_RETRY_EN
                        if (r_sel_a && !w_a_done) r_try_a <= r_try_a + 2'd1;
                        if (r_sel_b && !w_b_done) r_try_b <= r_try_b + 2'd1;
`endif
                        r_state <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - c_CNT_ONE;
                    end
                end
                S_RESP: begin
`ifdef ATS21_CMD_RETRY_EN
                    if (w_a_again || w_b_again) begin
                        r_sel_a  <= w_a_again;
                        r_sel_b  <= w_b_again;
                        r_ctrl_a <= w_a_again ? r_cmd_a[31:c_HI_LSB] : '0;
                        r_ctrl_b <= w_b_again ? r_cmd_b[31:c_HI_LSB] : '0;
                        r_req    <= 1'b1;
                        r_state  <= S_BEAT1;
                    end else begin
                        r_sel_a  <= 1'b0;
                        r_sel_b  <= 1'b0;
                        r_state  <= S_IDLE;
                    end
`else
                    r_sel_a <= 1'b0;
                    r_sel_b <= 1'b0;
                    r_state <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req         = r_req;
    assign ctrlA       = r_ctrl_a;
    assign ctrlB       = r_ctrl_b;
    assign a_rsp_valid = r_a_rsp_valid;
    assign a_rsp_ack   = r_a_rsp_ack;
    assign b_rsp_valid = r_b_rsp_valid;
    assign b_rsp_ack   = r_b_rsp_ack;
    assign busy        = (r_state != S_IDLE) || !w_a_empty || !w_b_empty;

endmodule
`default_nettype wire
